// File: rtl/axis_sync_fifo_pkg.sv
// axis_sync_fifo_pkg
//   Shared constants and helpers for the axis_sync_fifo slice.
//   - MEM_DISTRIBUTED / MEM_BLOCK : values of the C_MEMORY_TYPE storage hint.
//   - fifo_op_e                   : which side(s) of the FIFO act on an edge.
//   - decode_op()                 : maps accepted write/read strobes to fifo_op_e.
package axis_sync_fifo_pkg;

  localparam int MEM_DISTRIBUTED = 0;
  localparam int MEM_BLOCK       = 1;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    fifo_op_e op;
    case ({wr_ok, rd_ok})
      2'b00:   op = OP_IDLE;
      2'b01:   op = OP_RD;
      2'b10:   op = OP_WR;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_ram.sv
// axis_sync_fifo_ram
//   Simple dual-port storage array, C_DEPTH x C_DATA_WIDTH, one write port and
//   one combinational read port. The memory itself carries no reset; stored
//   words become meaningless whenever the owning FIFO resets its pointers.
// Ports:
//   clk    in  write clock
//   we     in  write strobe
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out word stored at raddr
module axis_sync_fifo_ram
  import axis_sync_fifo_pkg::*;
#(
  parameter string C_FAMILY      = "virtex6",
  parameter int    C_MEMORY_TYPE = 1,
  parameter int    C_DEPTH       = 256,
  parameter int    C_DATA_WIDTH  = 129,
  parameter int    C_PTR_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [C_PTR_WIDTH-1:0]  waddr,
  input  logic [C_DATA_WIDTH-1:0] wdata,
  input  logic [C_PTR_WIDTH-1:0]  raddr,
  output logic [C_DATA_WIDTH-1:0] rdata
);

  // The hint parameters only pick which inference template is used; both
  // templates behave identically. An empty family string falls back to the
  // distributed template since no block RAM mapping can be assumed.
  if (C_MEMORY_TYPE == MEM_DISTRIBUTED || C_FAMILY == "") begin : g_dist
    logic [C_DATA_WIDTH-1:0] mem_r [C_DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
    end

    assign rdata = mem_r[raddr];
  end else begin : g_block
    logic [C_DATA_WIDTH-1:0] mem_r [C_DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
    end

    assign rdata = mem_r[raddr];
  end

endmodule

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
//   Single-clock first-word-fall-through FIFO with a programmable-full flag.
//   Holds {tlast, ciphertext} words between the AES output pipeline and the
//   S2MM stream master. dout is a register that is preloaded with the word
//   that will be at the head after each edge, so a word written into an empty
//   FIFO is visible on dout in the very next cycle.
// Ports:
//   m_axi_mm2s_aclk         in  clock
//   mm2s_prmry_reset_out_n  in  asynchronous active-low reset
//   din                     in  write data
//   wr_en                   in  write request (ignored while full)
//   rd_en                   in  pop request (ignored while empty)
//   dout                    out head-of-FIFO word, valid while empty=0
//   full                    out occupancy == C_FIFO_DEPTH
//   empty                   out occupancy == 0
//   prog_full               out occupancy >= C_PROG_FULL_THRESH
//   data_count              out current occupancy
module axis_sync_fifo
  import axis_sync_fifo_pkg::*;
#(
  parameter string C_FAMILY           = "virtex6",
  parameter int    C_FIFO_DEPTH       = 256,
  parameter int    C_PROG_FULL_THRESH = 128,
  parameter int    C_DATA_WIDTH       = 129,
  parameter int    C_PTR_WIDTH        = 8,
  parameter int    C_MEMORY_TYPE      = 1
) (
  input  logic                    m_axi_mm2s_aclk,
  input  logic                    mm2s_prmry_reset_out_n,
  input  logic [C_DATA_WIDTH-1:0] din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [C_DATA_WIDTH-1:0] dout,
  output logic                    full,
  output logic                    empty,
  output logic                    prog_full,
  output logic [C_PTR_WIDTH:0]    data_count
);

  localparam logic [C_PTR_WIDTH:0]   DEPTH_C  = (C_PTR_WIDTH+1)'(C_FIFO_DEPTH);
  localparam logic [C_PTR_WIDTH:0]   THRESH_C = (C_PTR_WIDTH+1)'(C_PROG_FULL_THRESH);
  localparam logic [C_PTR_WIDTH:0]   CNT_ZERO_C = {(C_PTR_WIDTH+1){1'b0}};
  localparam logic [C_PTR_WIDTH:0]   CNT_ONE_C  = {{C_PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [C_PTR_WIDTH-1:0] PTR_ZERO_C = {C_PTR_WIDTH{1'b0}};
  localparam logic [C_PTR_WIDTH-1:0] PTR_ONE_C  = {{(C_PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_DATA_WIDTH-1:0] DATA_ZERO_C = {C_DATA_WIDTH{1'b0}};

  logic                    clk;
  logic                    rst_n;

  logic [C_PTR_WIDTH-1:0]  wr_ptr_r;
  logic [C_PTR_WIDTH-1:0]  rd_ptr_r;
  logic [C_PTR_WIDTH:0]    count_r;
  logic                    empty_r;
  logic                    full_r;
  logic                    prog_full_r;
  logic [C_DATA_WIDTH-1:0] dout_r;

  logic                    accept_wr_s;
  logic                    accept_rd_s;
  fifo_op_e                op_s;
  logic [C_PTR_WIDTH:0]    count_nxt_s;
  logic [C_PTR_WIDTH-1:0]  wr_ptr_nxt_s;
  logic [C_PTR_WIDTH-1:0]  rd_ptr_nxt_s;
  logic                    bypass_s;
  logic                    load_dout_s;
  logic [C_DATA_WIDTH-1:0] ram_rdata_s;
  logic [C_DATA_WIDTH-1:0] head_s;

  assign clk   = m_axi_mm2s_aclk;
  assign rst_n = mm2s_prmry_reset_out_n;

  // Acceptance is decided from registered flags only, so a write while full
  // or a read while empty leaves every piece of state untouched.
  assign accept_wr_s = wr_en & ~full_r;
  assign accept_rd_s = rd_en & ~empty_r;
  assign op_s        = decode_op(accept_wr_s, accept_rd_s);

  // Next occupancy; a simultaneous write and read leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      OP_IDLE: count_nxt_s = count_r;
      OP_WR:   count_nxt_s = count_r + CNT_ONE_C;
      OP_RD:   count_nxt_s = count_r - CNT_ONE_C;
      OP_BOTH: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer advance; depth is a power of two so wrap is the natural overflow.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (accept_wr_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (accept_rd_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Head word for the next cycle. When the word being written this edge is
  // the one that becomes the head (write into empty, or write+read at
  // occupancy 1), it is not in the array yet, so it is forwarded from din.
  // That is the only case where wr_ptr can equal the next read pointer with
  // a write accepted: equality otherwise means empty, or full with no write.
  always_comb begin
    bypass_s = 1'b0;
    head_s   = ram_rdata_s;
    if (accept_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      bypass_s = 1'b1;
      head_s   = din;
    end else begin
      bypass_s = 1'b0;
      head_s   = ram_rdata_s;
    end
  end

  // dout only moves when the head changes and the FIFO stays non-empty, so it
  // holds its last value while empty.
  assign load_dout_s = (accept_wr_s | accept_rd_s) & (count_nxt_s != CNT_ZERO_C);

  // Pointers, occupancy, flags and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      count_r     <= CNT_ZERO_C;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      prog_full_r <= 1'b0;
      dout_r      <= DATA_ZERO_C;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      empty_r     <= (count_nxt_s == CNT_ZERO_C);
      full_r      <= (count_nxt_s == DEPTH_C);
      prog_full_r <= (count_nxt_s >= THRESH_C);
      if (load_dout_s) begin
        dout_r <= head_s;
      end
    end
  end

  axis_sync_fifo_ram #(
    .C_FAMILY      (C_FAMILY),
    .C_MEMORY_TYPE (C_MEMORY_TYPE),
    .C_DEPTH       (C_FIFO_DEPTH),
    .C_DATA_WIDTH  (C_DATA_WIDTH),
    .C_PTR_WIDTH   (C_PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept_wr_s),
    .waddr (wr_ptr_r),
    .wdata (din),
    .raddr (rd_ptr_nxt_s),
    .rdata (ram_rdata_s)
  );

  assign dout       = dout_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign prog_full  = prog_full_r;
  assign data_count = count_r;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb_axis_sync_fifo
//   Scoreboard bench for axis_sync_fifo: the driver pushes each word it
//   expects the FIFO to accept; a monitor pops and compares whenever a read
//   of a non-empty FIFO is about to take effect. Flags and data_count are
//   compared against an occupancy model after every edge.
module tb_axis_sync_fifo;

  logic         clk;
  logic         rst_n;
  logic [128:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [128:0] dout;
  logic         full;
  logic         empty;
  logic         prog_full;
  logic [8:0]   data_count;

  int n_checks;
  int n_fail;
  int mcount;
  logic [128:0] exp_q [$];

  axis_sync_fifo #(
    .C_FAMILY           ("virtex6"),
    .C_FIFO_DEPTH       (256),
    .C_PROG_FULL_THRESH (128),
    .C_DATA_WIDTH       (129),
    .C_PTR_WIDTH        (8),
    .C_MEMORY_TYPE      (1)
  ) dut (
    .m_axi_mm2s_aclk        (clk),
    .mm2s_prmry_reset_out_n (rst_n),
    .din                    (din),
    .wr_en                  (wr_en),
    .rd_en                  (rd_en),
    .dout                   (dout),
    .full                   (full),
    .empty                  (empty),
    .prog_full              (prog_full),
    .data_count             (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read that the coming edge will accept consumes dout now.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dout_unexpected: got %h expected no word", dout);
      end else begin
        check("dout_order", dout, exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus, then model update and flag comparisons.
  task automatic step(input logic w, input logic [128:0] d, input logic r);
    logic aw;
    logic ar;
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    aw = w && (mcount < 256) && rst_n;
    ar = r && (mcount > 0) && rst_n;
    if (aw) exp_q.push_back(d);
    if (aw && !ar) mcount++;
    if (ar && !aw) mcount--;
    #1;
    check("empty", 129'(empty), 129'(mcount == 0));
    check("full", 129'(full), 129'(mcount == 256));
    check("prog_full", 129'(prog_full), 129'(mcount >= 128));
    check("data_count", 129'(data_count), 129'(mcount));
  endtask

  function automatic logic [128:0] word(input int v);
    return {v[0], 32'hA5A5_0000 | 32'(v), 32'(v), 32'hC3C3_C3C3, 32'(v * 7)};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mcount   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = 129'd1;

    // Reset held: writes must have no effect.
    for (int i = 0; i < 6; i++) begin
      step(i[0], 129'd1, 1'b0);
      check("reset_dout", dout, 129'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 129'd1, 1'b0);

    // FWFT latency: word visible right after the write edge.
    step(1'b1, 129'h1_00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    check("fwft_empty", 129'(empty), 129'd0);
    check("fwft_dout", dout, 129'h1_00112233_44556677_8899AABB_CCDDEEFF);
    step(1'b0, 129'd0, 1'b1);
    check("fwft_drained", 129'(data_count), 129'd0);

    // Threshold and full.
    for (int i = 0; i < 127; i++) step(1'b1, word(i), 1'b0);
    check("pf_below", 129'(prog_full), 129'd0);
    step(1'b1, word(127), 1'b0);
    check("pf_at", 129'(prog_full), 129'd1);
    check("cnt_128", 129'(data_count), 129'd128);
    for (int i = 128; i < 256; i++) step(1'b1, word(i), 1'b0);
    check("full_set", 129'(full), 129'd1);
    step(1'b1, 129'hDEAD, 1'b0);
    check("full_ignore", 129'(data_count), 129'd256);
    for (int i = 0; i < 256; i++) step(1'b0, 129'd0, 1'b1);

    // Wrap with small occupancy: write, read, both in rotation.
    begin
      int v;
      v = 0;
      for (int i = 0; i < 5; i++) begin
        step(1'b1, word(1000 + v), 1'b0);
        v++;
      end
      for (int i = 0; v < 300; i++) begin
        case (i % 3)
          0: begin step(1'b1, word(1000 + v), 1'b0); v++; end
          1: step(1'b0, 129'd0, 1'b1);
          default: begin step(1'b1, word(1000 + v), 1'b1); v++; end
        endcase
      end
      while (mcount > 0) step(1'b0, 129'd0, 1'b1);
    end

    // Simultaneous at occupancy 5.
    for (int i = 0; i < 5; i++) step(1'b1, word(2000 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, word(2005 + i), 1'b1);
      check("sim_cnt5", 129'(data_count), 129'd5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 129'd0, 1'b1);

    // Simultaneous at empty: write only.
    step(1'b1, word(3000), 1'b1);
    check("sim_empty", 129'(data_count), 129'd1);
    check("sim_empty_dout", dout, word(3000));
    step(1'b0, 129'd0, 1'b1);

    // Simultaneous at full: read only.
    for (int i = 0; i < 256; i++) step(1'b1, word(4000 + i), 1'b0);
    step(1'b1, 129'hBEEF, 1'b1);
    check("sim_full", 129'(data_count), 129'd255);
    for (int i = 0; i < 255; i++) step(1'b0, 129'd0, 1'b1);

    // Asynchronous reset mid-stream at occupancy 40.
    for (int i = 0; i < 40; i++) step(1'b1, word(5000 + i), 1'b0);
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 129'(empty), 129'd1);
    check("arst_cnt", 129'(data_count), 129'd0);
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, word(6000 + i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 129'd0, 1'b1);
    step(1'b0, 129'd0, 1'b0);
    check("queue_drained", 129'(exp_q.size()), 129'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
